// File: rtl/nios_system_nios2_div_cell.sv
// Restoring radix-2 divider (DIV/DIVU): one quotient bit per clock, start/busy/done handshake.
// Optional NIOS2_DIV_CELL_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module nios_system_nios2_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_div_start,
  input  logic             M_div_signed,
  input  logic [WIDTH-1:0] M_div_src1,
  input  logic [WIDTH-1:0] M_div_src2,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quotient,
  output logic [WIDTH-1:0] M_div_remainder,
  output logic             M_div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             q_bit;

  always_comb begin
    mag1 = (M_div_signed && M_div_src1[WIDTH-1]) ? -M_div_src1 : M_div_src1;
    mag2 = (M_div_signed && M_div_src2[WIDTH-1]) ? -M_div_src2 : M_div_src2;
  end

  // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    q_bit   = (rem_sh >= {1'b0, dvs});
  end

  assign M_div_busy = (state != S_IDLE);
  assign M_div_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      count           <= '0;
      dvd             <= '0;
      dvs             <= '0;
      rem             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      M_div_quotient  <= '0;
      M_div_remainder <= '0;
      M_div_by_zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (M_div_start) begin
            dvd   <= mag1;
            dvs   <= mag2;
            rem   <= '0;
            count <= '0;
            neg_q <= M_div_signed & (M_div_src1[WIDTH-1] ^ M_div_src2[WIDTH-1]);
            neg_r <= M_div_signed & M_div_src1[WIDTH-1];
            if (M_div_src2 == '0) begin
              // Raw dividend is returned, not its magnitude.
              M_div_quotient  <= '1;
              M_div_remainder <= M_div_src1;
              M_div_by_zero   <= 1'b1;
              state           <= S_DONE;
`ifdef NIOS2_DIV_CELL_EARLY_OUT_EN
            end else if (mag1 < mag2) begin
              dvd   <= '0;
              rem   <= mag1;
              state <= S_FIX;
`endif
            end else begin
              state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          rem   <= q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], q_bit};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          M_div_quotient  <= neg_q ? -dvd : dvd;
          M_div_remainder <= neg_r ? -rem : rem;
          M_div_by_zero   <= 1'b0;
          state           <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
